// File: rtl/osc_pkg.sv
// Shared note table and divider math for the polyphonic tone generator.
package osc_pkg;

  localparam int unsigned NOTE_TAB_LEN = 32;
  localparam int unsigned NOTE_REST    = 0;

  // Equal-temperament frequencies in centi-Hz; index 1 = C4, index 0 = rest.
  localparam int unsigned NOTE_CHZ [NOTE_TAB_LEN] = '{
    0,
    26163, 27718, 29366, 31113, 32963, 34923, 36999, 39200, 41530, 44000, 46616, 49388,
    52325, 55437, 58733, 62225, 65926, 69846, 73999, 78399, 83061, 88000, 93233, 98777,
    104650, 110873, 117466, 124451, 131851, 139691, 147998
  };

  // Frequency lookup that tolerates note indices beyond the table.
  function automatic longint unsigned note_chz(input int unsigned idx);
    if (idx >= NOTE_TAB_LEN) return 64'd0;
    return 64'(NOTE_CHZ[idx]);
  endfunction

  // Half-period in clock cycles, rounded to nearest: clk_hz*100 / (2*f_chz).
  function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                  input longint unsigned f_chz);
    if (f_chz == 64'd0) return 64'd0;
    return (clk_hz * 64'd50 + f_chz / 64'd2) / f_chz;
  endfunction

endpackage

// File: rtl/osc_voice.sv
// One square-wave voice with a glitch-free pending divider.
module osc_voice
  import osc_pkg::*;
#(
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned DIV_W  = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [NOTE_W-1:0] note,
  input  logic [DIV_W-1:0]  load_div,
  output logic              voice_out,
  output logic              voice_active
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pend_div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             pend_v_q;
  logic             is_rest_c;
  logic             wrap_c;

  assign is_rest_c = (note == NOTE_W'(NOTE_REST));
  assign wrap_c    = voice_active && (cnt_q == div_q - DIV_W'(1));

  // Note start/stop, half-period counting and pending-divider promotion on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= '0;
      pend_div_q   <= '0;
      cnt_q        <= '0;
      pend_v_q     <= 1'b0;
      voice_out    <= 1'b0;
      voice_active <= 1'b0;
    end else if (load && is_rest_c) begin
      cnt_q        <= '0;
      pend_v_q     <= 1'b0;
      voice_out    <= 1'b0;
      voice_active <= 1'b0;
    end else if (load && !voice_active) begin
      div_q        <= load_div;
      cnt_q        <= '0;
      pend_v_q     <= 1'b0;
      voice_out    <= 1'b0;
      voice_active <= 1'b1;
    end else begin
      if (voice_active) begin
        if (wrap_c) begin
          cnt_q     <= '0;
          voice_out <= ~voice_out;
          if (pend_v_q) begin
            div_q    <= pend_div_q;
            pend_v_q <= 1'b0;
          end
        end else begin
          cnt_q <= cnt_q + DIV_W'(1);
        end
      end
      // A load here always targets a sounding voice: park it until the next wrap.
      if (load) begin
        pend_div_q <= load_div;
        pend_v_q   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/poly_oscillator.sv
// Multi-voice square-wave generator with a PWM speaker mix.
module poly_oscillator
  import osc_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned VOICES = 4,
  parameter int unsigned NOTE_W = 5,
  parameter int unsigned DIV_W  = 17,
  localparam int unsigned SEL_W = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [SEL_W-1:0]  voice_sel,
  input  logic [NOTE_W-1:0] note,
  output logic [VOICES-1:0] voice_out,
  output logic [VOICES-1:0] voice_active,
  output logic              speaker
);

  localparam int unsigned    TAB_LEN = 1 << NOTE_W;
  localparam int unsigned    CNT_W   = $clog2(VOICES + 1);
  localparam longint unsigned MAX_DIV = half_period(64'(CLK_HZ), note_chz(1));

  if (VOICES < 1 || VOICES > 16) begin : g_bad_voices
    $error("poly_oscillator: VOICES must be in 1..16");
  end

  if (DIV_W < 64 && MAX_DIV >= (64'd1 << DIV_W)) begin : g_bad_div_w
    $error("poly_oscillator: DIV_W too narrow for the lowest note");
  end

  logic [DIV_W-1:0] div_tab [TAB_LEN];
  logic [DIV_W-1:0] load_div_c;
  logic [CNT_W-1:0] high_cnt_c;
  logic [SEL_W-1:0] pwm_cnt_q;

  // Elaboration-time divider table, one entry per note index.
  for (genvar g = 0; g < TAB_LEN; g++) begin : g_tab
    localparam longint unsigned HP = half_period(64'(CLK_HZ), note_chz(g));
    assign div_tab[g] = DIV_W'(HP);
  end

  assign load_div_c = div_tab[note];

  // Voice array; out-of-range selects match no voice and are dropped.
  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    osc_voice #(
      .NOTE_W (NOTE_W),
      .DIV_W  (DIV_W)
    ) u_voice (
      .clk          (clk),
      .rst_n        (rst_n),
      .load         (load && (voice_sel == SEL_W'(v))),
      .note         (note),
      .load_div     (load_div_c),
      .voice_out    (voice_out[v]),
      .voice_active (voice_active[v])
    );
  end

  // Count how many voices are currently high.
  always_comb begin
    high_cnt_c = '0;
    for (int unsigned i = 0; i < VOICES; i++) begin
      high_cnt_c = high_cnt_c + CNT_W'(voice_out[i]);
    end
  end

  // PWM slot counter and registered speaker bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
      speaker   <= 1'b0;
    end else begin
      if (pwm_cnt_q == SEL_W'(VOICES - 1)) pwm_cnt_q <= '0;
      else                                 pwm_cnt_q <= pwm_cnt_q + SEL_W'(1);
      speaker <= (CNT_W'(pwm_cnt_q) < high_cnt_c);
    end
  end

endmodule

// File: tb/tb_poly_oscillator.sv
// Scoreboarded bench: expected voice edges are queued by the stimulus, popped by an edge monitor.
module tb_poly_oscillator;

  localparam int unsigned NV      = 4;
  // Half-periods at a 1 MHz clock: round(1e6*50 / f_cHz)
  localparam int unsigned HP_C4   = 1911;
  localparam int unsigned HP_A4   = 1136;
  localparam int unsigned HP_C5   = 956;
  localparam int unsigned HP_FS6  = 338;

  typedef struct {
    int unsigned at;
    logic        lvl;
  } edge_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [1:0]    voice_sel;
  logic [4:0]    note;
  logic [NV-1:0] voice_out;
  logic [NV-1:0] voice_active;
  logic          speaker;

  logic          load_m;
  logic [0:0]    sel_m;
  logic [4:0]    note_m;
  logic [0:0]    out_m;
  logic [0:0]    act_m;
  logic          spk_m;

  int unsigned   cyc = 0;
  int            checks = 0;
  int            failures = 0;
  edge_t         exp_q [NV][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  poly_oscillator #(
    .CLK_HZ (1_000_000),
    .VOICES (NV),
    .NOTE_W (5),
    .DIV_W  (17)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .voice_sel    (voice_sel),
    .note         (note),
    .voice_out    (voice_out),
    .voice_active (voice_active),
    .speaker      (speaker)
  );

  poly_oscillator #(
    .CLK_HZ (1_000_000),
    .VOICES (1),
    .NOTE_W (5),
    .DIV_W  (17)
  ) u_mono (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load_m),
    .voice_sel    (sel_m),
    .note         (note_m),
    .voice_out    (out_m),
    .voice_active (act_m),
    .speaker      (spk_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_edge(input int v, input int unsigned at, input logic lvl);
    edge_t e;
    e.at  = at;
    e.lvl = lvl;
    exp_q[v].push_back(e);
  endtask

  // Called on a negedge; load is sampled by the next posedge (accept cycle = acc).
  task automatic issue(input int unsigned sel, input int unsigned n, output int unsigned acc);
    load      = 1'b1;
    voice_sel = 2'(sel);
    note      = 5'(n);
    acc       = cyc + 1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  task automatic wait_until(input int unsigned t);
    checks++;
    if (cyc > t) begin
      failures++;
      $display("FAIL schedule: at cycle %0d, required at most %0d", cyc, t);
    end
    while (cyc < t) @(negedge clk);
  endtask

  task automatic count_ones(input int n, output int unsigned ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (speaker === 1'b1) ones++;
    end
  endtask

  // Edge monitor: every voice_out transition must match the head of that voice's queue.
  initial begin
    logic [NV-1:0] prev;
    edge_t         e;
    prev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = '0;
      end else begin
        for (int v = 0; v < NV; v++) begin
          if (voice_out[v] !== prev[v]) begin
            checks++;
            if (exp_q[v].size() == 0) begin
              failures++;
              $display("FAIL edge_v%0d: edge to %b at cycle %0d, required no edge", v, voice_out[v], cyc);
            end else begin
              e = exp_q[v].pop_front();
              if (e.at != cyc || e.lvl !== voice_out[v]) begin
                failures++;
                $display("FAIL edge_v%0d: level %b at cycle %0d, required level %b at cycle %0d",
                         v, voice_out[v], cyc, e.lvl, e.at);
              end
            end
          end
        end
        prev = voice_out;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: still running at cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned a, b, p, q, x, ones, errs, lvl_now, lvl_prev;

    // Reset held with a load pending: nothing may be captured
    rst_n = 1'b0; load = 1'b1; voice_sel = 2'd0; note = 5'd10;
    load_m = 1'b1; sel_m = 1'b0; note_m = 5'd10;
    repeat (3) @(negedge clk);
    check("rst_voice_out", voice_out, 0);
    check("rst_active", voice_active, 0);
    check("rst_speaker", speaker, 0);
    check("rst_mono", {spk_m, act_m, out_m}, 0);
    load = 1'b0; load_m = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_active", voice_active, 0);
    check("post_rst_out", {speaker, voice_out}, 0);

    // Single-voice instance: out-of-range select, then speaker = voice_out delayed
    load_m = 1'b1; sel_m = 1'b1; note_m = 5'd10;
    @(negedge clk);
    load_m = 1'b0;
    repeat (4) @(negedge clk);
    check("mono_oor_state", {act_m, out_m}, 0);
    load_m = 1'b1; sel_m = 1'b0; note_m = 5'd31; a = cyc + 1;
    @(negedge clk);
    load_m = 1'b0;
    check("mono_active", act_m, 1);
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      lvl_now  = ((cyc - a) / HP_FS6) % 2;
      lvl_prev = ((cyc - 1 - a) / HP_FS6) % 2;
      if (out_m !== 1'(lvl_now) || spk_m !== 1'(lvl_prev)) errs++;
    end
    check("mono_wave_errors", errs, 0);
    load_m = 1'b1; note_m = 5'd0;
    @(negedge clk);
    load_m = 1'b0;
    check("mono_rest", {act_m, out_m}, 0);

    // A4 on voice 0, then rest while high
    issue(0, 10, a);
    check("a4_active", voice_active, 4'b0001);
    push_edge(0, a + HP_A4, 1'b1);
    push_edge(0, a + 2 * HP_A4, 1'b0);
    push_edge(0, a + 3 * HP_A4, 1'b1);
    wait_until(a + 4000);
    push_edge(0, cyc + 1, 1'b0);
    issue(0, 0, x);
    check("rest_active", voice_active, 0);
    check("rest_out", voice_out, 0);

    // C4 on voice 1, two changes mid half-period; last write (C5) wins at the wrap
    issue(1, 1, b);
    check("c4_active", voice_active, 4'b0010);
    push_edge(1, b + HP_C4, 1'b1);
    wait_until(b + 2410);
    issue(1, 31, x);
    wait_until(b + 2910);
    issue(1, 13, x);
    check("chg_active", voice_active, 4'b0010);
    push_edge(1, b + 2 * HP_C4, 1'b0);
    push_edge(1, b + 2 * HP_C4 + HP_C5, 1'b1);
    push_edge(1, b + 2 * HP_C4 + 2 * HP_C5, 1'b0);
    push_edge(1, b + 2 * HP_C4 + 3 * HP_C5, 1'b1);
    wait_until(b + 7000);
    check("chg_level", voice_out, 4'b0010);

    // Three voices sounding, then asynchronous reset between clock edges
    issue(0, 31, p);
    issue(2, 31, q);
    push_edge(0, p + HP_FS6, 1'b1);
    push_edge(2, q + HP_FS6, 1'b1);
    wait_until(p + 400);
    check("three_active", voice_active, 4'b0111);
    check("three_out", voice_out, 4'b0111);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", voice_out, 0);
    check("async_active", voice_active, 0);
    check("async_speaker", speaker, 0);
    for (int v = 0; v < NV; v++) exp_q[v].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_async_active", voice_active, 0);

    // Mixer: none high, two high, then all four high
    issue(0, 1, a);
    issue(2, 1, x);
    push_edge(0, a + HP_C4, 1'b1);
    push_edge(2, a + 1 + HP_C4, 1'b1);
    push_edge(0, a + 2 * HP_C4, 1'b0);
    push_edge(2, a + 1 + 2 * HP_C4, 1'b0);
    push_edge(0, a + 3 * HP_C4, 1'b1);
    push_edge(2, a + 1 + 3 * HP_C4, 1'b1);
    wait_until(a + 100);
    count_ones(16, ones);
    check("mix_none_high", ones, 0);
    wait_until(a + 1920);
    for (int w = 0; w < 4; w++) begin
      count_ones(4, ones);
      check("mix_two_of_four", ones, 2);
    end
    wait_until(a + 2 * HP_C4 - 1);
    issue(1, 1, x);
    issue(3, 1, x);
    push_edge(1, a + 3 * HP_C4, 1'b1);
    push_edge(3, a + 1 + 3 * HP_C4, 1'b1);
    wait_until(a + 3 * HP_C4 + 7);
    check("mix_all_out", voice_out, 4'b1111);
    count_ones(16, ones);
    check("mix_all_high", ones, 16);

    for (int v = 0; v < NV; v++) begin
      checks++;
      if (exp_q[v].size() != 0) begin
        failures++;
        $display("FAIL missed_edges_v%0d: %0d edges still expected, required 0", v, exp_q[v].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
